// File: rtl/feistel_cipher_iter.sv
// Iterative balanced Feistel block cipher: one round per clock, runtime
// encrypt/decrypt selection, valid/ready handshakes on input and output.
// Decryption reuses the same round datapath and only walks the key schedule
// backwards, so the two directions are guaranteed to be exact inverses.
module feistel_cipher_iter #(
  parameter int W      = 64,
  parameter int ROUNDS = 16,
  parameter int KROT   = 4,
  parameter int FROT   = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic [W-1:0] in_key,
  input  logic         in_decrypt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy
);

  localparam int H  = W / 2;
  localparam int CW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CW-1:0] LAST_ROUND = CW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [H-1:0]  half_l;
  logic [H-1:0]  half_r;
  logic [W-1:0]  key_q;
  logic          decrypt_q;
  logic [CW-1:0] round_cnt;
  logic [W-1:0]  result_q;

  int            round_idx;
  int            rot_amt;
  logic [H-1:0]  round_key;
  logic [H-1:0]  f_out;
  logic [H-1:0]  new_r;
  logic          last_round;

  // Cyclic left rotation of a full-width word by a run-time amount below W.
  function automatic logic [W-1:0] rotl_w(input logic [W-1:0] x, input int n);
    if (n == 0) begin
      return x;
    end
    return (x << n) | (x >> (W - n));
  endfunction

  // Cyclic left rotation of a half-width word by the fixed round-function amount.
  function automatic logic [H-1:0] rotl_h(input logic [H-1:0] x);
    if (FROT == 0) begin
      return x;
    end
    return (x << FROT) | (x >> (H - FROT));
  endfunction

  // Key schedule and round function; decryption simply visits rounds in reverse order.
  always_comb begin
    round_idx  = 0;
    rot_amt    = 0;
    round_idx  = decrypt_q ? (ROUNDS - 1 - int'(round_cnt)) : int'(round_cnt);
    rot_amt    = (KROT * round_idx) % W;
    round_key  = H'(rotl_w(key_q, rot_amt));
    f_out      = rotl_h(half_r ^ round_key) + round_key;
    new_r      = half_l ^ f_out;
    last_round = (round_cnt == LAST_ROUND);
  end

  // State register; reset aborts any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and handshake outputs; inputs only matter in IDLE.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    out_data   = result_q;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_round) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: capture a block in IDLE, apply one round per RUN cycle, and
  // publish the swapped halves on the last round so DONE just holds it.
  always_ff @(posedge clk) begin
    if (rst) begin
      half_l    <= '0;
      half_r    <= '0;
      key_q     <= '0;
      decrypt_q <= 1'b0;
      round_cnt <= '0;
      result_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            half_l    <= in_data[W-1:H];
            half_r    <= in_data[H-1:0];
            key_q     <= in_key;
            decrypt_q <= in_decrypt;
            round_cnt <= '0;
          end
        end
        RUN: begin
          half_l    <= half_r;
          half_r    <= new_r;
          round_cnt <= round_cnt + 1'b1;
          if (last_round) begin
            result_q <= {new_r, half_r};
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feistel_cipher_iter.sv
// Self-checking bench for feistel_cipher_iter: three instances cover a
// one-round 64-bit engine, the default configuration and a small 16-bit one.
module tb_feistel_cipher_iter;

  logic clk = 1'b0;
  logic rst;

  logic        a_in_valid, a_in_ready, a_in_decrypt, a_out_valid, a_out_ready, a_busy;
  logic [63:0] a_in_data, a_in_key, a_out_data;
  logic        d_in_valid, d_in_ready, d_in_decrypt, d_out_valid, d_out_ready, d_busy;
  logic [63:0] d_in_data, d_in_key, d_out_data;
  logic        s_in_valid, s_in_ready, s_in_decrypt, s_out_valid, s_out_ready, s_busy;
  logic [15:0] s_in_data, s_in_key, s_out_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] data;
    logic [63:0] key;
    bit          dec;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[6];

  // Free-running clock shared by all instances.
  always #5 clk = ~clk;

  feistel_cipher_iter #(.W(64), .ROUNDS(1), .KROT(4), .FROT(3)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_key(a_in_key), .in_decrypt(a_in_decrypt),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
  );

  feistel_cipher_iter dut_d (
    .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_data(d_in_data), .in_key(d_in_key), .in_decrypt(d_in_decrypt),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data), .busy(d_busy)
  );

  feistel_cipher_iter #(.W(16), .ROUNDS(4), .KROT(4), .FROT(3)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_key(s_in_key), .in_decrypt(s_in_decrypt),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .busy(s_busy)
  );

  // Cyclic rotation of the low 'width' bits of x.
  function automatic logic [63:0] rotl(input logic [63:0] x, input int n, input int width);
    logic [63:0] mask;
    int          m;
    mask = (width == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << width) - 64'd1);
    m = n % width;
    x = x & mask;
    if (m == 0) return x;
    return ((x << m) | (x >> (width - m))) & mask;
  endfunction

  // Reference cipher: build the whole key list, reverse it for decryption,
  // run the textbook Feistel rounds, then swap halves.
  function automatic logic [63:0] model(input int w, input int rounds, input int krot,
                                        input int frot, input logic [63:0] data,
                                        input logic [63:0] key, input bit dec);
    int          h;
    logic [63:0] hm, l, r, f, t;
    logic [63:0] ks[$];
    h  = w / 2;
    hm = (64'd1 << h) - 64'd1;
    for (int j = 0; j < rounds; j++) ks.push_back(rotl(key, krot * j, w) & hm);
    if (dec) ks.reverse();
    l = (data >> h) & hm;
    r = data & hm;
    foreach (ks[i]) begin
      f = (rotl(r ^ ks[i], frot, h) + ks[i]) & hm;
      t = l ^ f;
      l = r;
      r = t;
    end
    return (r << h) | l;
  endfunction

  function automatic logic out_valid_of(input int which);
    case (which)
      0:       return a_out_valid;
      1:       return d_out_valid;
      default: return s_out_valid;
    endcase
  endfunction

  function automatic logic [63:0] out_data_of(input int which);
    case (which)
      0:       return a_out_data;
      1:       return d_out_data;
      default: return {48'd0, s_out_data};
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Push one block into the chosen instance, wait (bounded) for the result,
  // then hand it off. Latency counts edges after the accepting edge.
  task automatic applyStimulus(input int which, input logic [63:0] data, input logic [63:0] key,
                               input bit dec, output logic [63:0] result, output int lat);
    @(negedge clk);
    case (which)
      0: begin a_in_data = data; a_in_key = key; a_in_decrypt = dec; a_in_valid = 1'b1; end
      1: begin d_in_data = data; d_in_key = key; d_in_decrypt = dec; d_in_valid = 1'b1; end
      default: begin
        s_in_data = data[15:0]; s_in_key = key[15:0]; s_in_decrypt = dec; s_in_valid = 1'b1;
      end
    endcase
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    d_in_valid = 1'b0;
    s_in_valid = 1'b0;
    lat = 0;
    while (!out_valid_of(which) && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    result = out_data_of(which);
    case (which)
      0:       a_out_ready = 1'b1;
      1:       d_out_ready = 1'b1;
      default: s_out_ready = 1'b1;
    endcase
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    d_out_ready = 1'b0;
    s_out_ready = 1'b0;
  endtask

  logic [63:0] res, res2, ct, snap, exp_ct;
  logic [15:0] x16, k16;
  int          lat;
  bit          pulsed;

  initial begin
    rst = 1'b1;
    a_in_valid = 0; a_in_decrypt = 0; a_out_ready = 0; a_in_data = '0; a_in_key = '0;
    d_in_valid = 0; d_in_decrypt = 0; d_out_ready = 0; d_in_data = '0; d_in_key = '0;
    s_in_valid = 0; s_in_decrypt = 0; s_out_ready = 0; s_in_data = '0; s_in_key = '0;

    // Reset state of every instance.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready_a", a_in_ready, 1);
    checkOutput("reset_out_valid_a", a_out_valid, 0);
    checkOutput("reset_out_data_a", a_out_data, 0);
    checkOutput("reset_busy_a", a_busy, 0);
    checkOutput("reset_in_ready_d", d_in_ready, 1);
    checkOutput("reset_out_valid_d", d_out_valid, 0);
    checkOutput("reset_out_data_d", d_out_data, 0);
    checkOutput("reset_busy_s", s_busy, 0);
    rst = 1'b0;

    // One-round 64-bit vectors.
    vecs[0] = '{64'h0000000100000002, 64'h0, 1'b0, 64'h0000001100000002};
    vecs[1] = '{64'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'hFFFFFFFE00000000};
    vecs[2] = '{64'h0000001100000002, 64'h0, 1'b1, 64'h0000000100000002};
    vecs[3] = '{64'hFFFFFFFE00000000, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0};
    for (int i = 4; i < 6; i++) begin
      vecs[i].data = {$urandom, $urandom};
      vecs[i].key  = {$urandom, $urandom};
      vecs[i].dec  = 1'(i - 4);
      vecs[i].exp  = model(64, 1, 4, 3, vecs[i].data, vecs[i].key, vecs[i].dec);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, vecs[i].data, vecs[i].key, vecs[i].dec, res, lat);
      checkOutput($sformatf("r1_vec%0d_data", i), res, vecs[i].exp);
      checkOutput($sformatf("r1_vec%0d_latency", i), 64'(lat), 64'd1);
    end

    // Default configuration round trip.
    exp_ct = model(64, 16, 4, 3, 64'h0123456789ABCDEF, 64'h0F1E2D3C4B5A6978, 1'b0);
    applyStimulus(1, 64'h0123456789ABCDEF, 64'h0F1E2D3C4B5A6978, 1'b0, ct, lat);
    checkOutput("def_encrypt_data", ct, exp_ct);
    checkOutput("def_encrypt_latency", 64'(lat), 64'd16);
    applyStimulus(1, ct, 64'h0F1E2D3C4B5A6978, 1'b1, res, lat);
    checkOutput("def_decrypt_data", res, 64'h0123456789ABCDEF);
    checkOutput("def_decrypt_latency", 64'(lat), 64'd16);

    // Backpressure: result held while the consumer stalls, inputs ignored.
    @(negedge clk);
    d_in_data = 64'hDEADBEEFCAFEF00D; d_in_key = 64'h1122334455667788; d_in_decrypt = 1'b0;
    d_in_valid = 1'b1;
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
    lat = 0;
    while (!d_out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("bp_latency", 64'(lat), 64'd16);
    snap = d_out_data;
    checkOutput("bp_data", snap, model(64, 16, 4, 3, 64'hDEADBEEFCAFEF00D, 64'h1122334455667788, 1'b0));
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      d_in_valid = c[0] ? 1'b0 : 1'b1;
      d_in_data  = {$urandom, $urandom};
      d_in_decrypt = 1'b1;
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_hold%0d_data", c), d_out_data, snap);
      checkOutput($sformatf("bp_hold%0d_out_valid", c), d_out_valid, 1);
      checkOutput($sformatf("bp_hold%0d_in_ready", c), d_in_ready, 0);
    end
    @(negedge clk);
    d_in_valid = 1'b0;
    d_out_ready = 1'b1;
    @(posedge clk);
    #1;
    d_out_ready = 1'b0;
    checkOutput("bp_handoff_out_valid", d_out_valid, 0);
    checkOutput("bp_handoff_in_ready", d_in_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_after_busy", d_busy, 0);

    // Reset in the middle of a block.
    @(negedge clk);
    d_in_data = 64'h0123456789ABCDEF; d_in_key = 64'h0F1E2D3C4B5A6978; d_in_decrypt = 1'b0;
    d_in_valid = 1'b1;
    @(posedge clk);
    #1;
    d_in_valid = 1'b0;
    pulsed = 1'b0;
    repeat (7) begin
      @(posedge clk);
      #1;
      if (d_out_valid) pulsed = 1'b1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_no_pulse", 64'(pulsed), 64'd0);
    checkOutput("abort_in_ready", d_in_ready, 1);
    checkOutput("abort_out_valid", d_out_valid, 0);
    checkOutput("abort_out_data", d_out_data, 0);
    checkOutput("abort_busy", d_busy, 0);
    applyStimulus(1, 64'h0123456789ABCDEF, 64'h0F1E2D3C4B5A6978, 1'b0, res, lat);
    checkOutput("abort_fresh_data", res, exp_ct);
    checkOutput("abort_fresh_latency", 64'(lat), 64'd16);

    // Small configuration, random round trips against the model.
    for (int n = 0; n < 200; n++) begin
      x16 = 16'($urandom);
      k16 = 16'($urandom);
      applyStimulus(2, {48'd0, x16}, {48'd0, k16}, 1'b0, res, lat);
      checkOutput($sformatf("rand%0d_encrypt", n), res, model(16, 4, 4, 3, {48'd0, x16}, {48'd0, k16}, 1'b0));
      applyStimulus(2, res, {48'd0, k16}, 1'b1, res2, lat);
      checkOutput($sformatf("rand%0d_roundtrip", n), res2, {48'd0, x16});
    end
    checkOutput("rand_last_latency", 64'(lat), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
